instr_fetch: RTL and testbench

Producer side of the 9-bit instruction interface consumed by the R.O.E control decoder.
- Owns the program counter and issues reads to the synchronous instruction memory.
- Presents each fetched instruction to the decode stage through a valid/ready handshake.
- Handles branch redirects from execute and stops on a HALT encoding, reporting program completion.

---
 rtl/instr_fetch.sv | 148 ++++++++++++++
 tb/tb_instr_fetch.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads the synchronous instruction memory and
// hands instructions to decode over valid/ready. Optional FETCH_COUNT_EN adds instr_count.
module instr_fetch #(
  parameter int unsigned           PC_W      = 10,
  parameter int unsigned           INSTR_W   = 9,
  parameter logic [INSTR_W-1:0]    HALT_CODE = 9'h1FF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PC_W-1:0]    start_addr,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    pc,
`ifdef FETCH_COUNT_EN
  output logic [15:0]        instr_count,
`endif
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 req_q, req_d;
  logic                 done_q, done_d;
  logic                 active_c;

  assign active_c = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_HOLD);

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    done_d  = done_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pc_d    = start_addr;
          done_d  = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        instr_d = imem_rdata;
        valid_d = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          if (instr_q == HALT_CODE) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect wins over acceptance and HALT; in-flight read data is dropped
    if (branch_taken && active_c) begin
      pc_d    = branch_target;
      instr_d = instr_q;
      valid_d = 1'b0;
      done_d  = 1'b0;
      state_d = S_FETCH;
    end

    req_d = (state_d == S_FETCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = req_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign done        = done_q;

`ifdef FETCH_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        accept_c;
  logic        restart_c;

  assign accept_c  = (state_q == S_HOLD) && instr_ready;
  assign restart_c = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Saturating count of accepted instructions, including HALT and branch-accepts
  always_comb begin
    cnt_d = cnt_q;
    if (restart_c) begin
      cnt_d = '0;
    end else if (accept_c && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a synchronous instruction memory model.
module tb_instr_fetch;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [9:0] start_addr;
  logic       imem_req;
  logic [9:0] imem_addr;
  logic [8:0] imem_rdata;
  logic [8:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       branch_taken;
  logic [9:0] branch_target;
  logic [9:0] pc;
  logic       done;
`ifdef FETCH_COUNT_EN
  logic [15:0] instr_count;
`endif

  int total;
  int bad;

  logic [8:0] mem [0:1023];

  instr_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .start_addr    (start_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
`ifdef FETCH_COUNT_EN
    .instr_count   (instr_count),
`endif
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns data one cycle after the read strobe
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 9'(i & 8'hFF);
    mem[5]     = 9'h0A3;
    mem[8]     = 9'h1FF;
    mem[10'h3FF] = 9'h155;
    imem_rdata    = '0;
    rst_n         = 1'b0;
    start         = 1'b0;
    start_addr    = '0;
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;

    // Reset state
    tick(); tick();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // Start at 5
    start = 1'b1; start_addr = 10'd5;
    tick();
    start = 1'b0;
    check("start_req", 32'(imem_req), 32'd1);
    check("start_addr", 32'(imem_addr), 32'd5);
    tick();
    check("wait_req", 32'(imem_req), 32'd0);
    check("wait_valid", 32'(instr_valid), 32'd0);
    tick();
    check("hold_instr", 32'(instr), 32'h0A3);
    check("hold_valid", 32'(instr_valid), 32'd1);

    // Backpressure for 4 cycles
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_instr", 32'(instr), 32'h0A3);
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_req", 32'(imem_req), 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    check("acc_pc", 32'(pc), 32'd6);
    check("acc_valid", 32'(instr_valid), 32'd0);
    check("acc_req", 32'(imem_req), 32'd1);

    // Ready tied high: 6, 7, then HALT at 8
    tick(); tick();
    check("i6_instr", 32'(instr), 32'h006);
    tick();
    check("i7_pc", 32'(pc), 32'd7);
    tick(); tick();
    check("i7_instr", 32'(instr), 32'h007);
    tick();
    tick(); tick();
    check("halt_instr", 32'(instr), 32'h1FF);
    check("halt_pc", 32'(pc), 32'd8);
    tick();
    check("done_set", 32'(done), 32'd1);
    check("done_valid", 32'(instr_valid), 32'd0);
    check("done_pc", 32'(pc), 32'd8);
    check("done_req", 32'(imem_req), 32'd0);
    branch_taken = 1'b1; branch_target = 10'd77;
    tick();
    branch_taken = 1'b0;
    check("done_br_ign_pc", 32'(pc), 32'd8);
    check("done_stays", 32'(done), 32'd1);
    check("done_req2", 32'(imem_req), 32'd0);

    // Restart at 0 clears done
    start = 1'b1; start_addr = 10'd0;
    tick();
    start = 1'b0;
    check("restart_done", 32'(done), 32'd0);
    check("restart_pc", 32'(pc), 32'd0);
    check("restart_req", 32'(imem_req), 32'd1);

    // Branch in WAIT
    tick();
    branch_taken = 1'b1; branch_target = 10'd40;
    tick();
    branch_taken = 1'b0;
    check("brw_valid", 32'(instr_valid), 32'd0);
    check("brw_addr", 32'(imem_addr), 32'd40);
    check("brw_req", 32'(imem_req), 32'd1);
    tick();
    check("brw_wait_valid", 32'(instr_valid), 32'd0);
    tick();
    check("brw_instr", 32'(instr), 32'h028);
    check("brw_hold_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b0;

    // Branch to HALT location, then branch together with HALT accept
    branch_taken = 1'b1; branch_target = 10'd8;
    tick();
    branch_taken = 1'b0;
    check("brh_pc", 32'(pc), 32'd8);
    tick(); tick();
    check("brh_instr", 32'(instr), 32'h1FF);
    instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 10'd100;
    tick();
    instr_ready = 1'b0; branch_taken = 1'b0;
    check("brh_no_done", 32'(done), 32'd0);
    check("brh_tgt_pc", 32'(pc), 32'd100);
    check("brh_req", 32'(imem_req), 32'd1);
    check("brh_valid", 32'(instr_valid), 32'd0);

    // Asynchronous reset during WAIT
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_pc", 32'(pc), 32'd0);
    check("arst_instr", 32'(instr), 32'd0);
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_req", 32'(imem_req), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // PC wrap from 3FF
    start = 1'b1; start_addr = 10'h3FF;
    tick();
    start = 1'b0;
    tick(); tick();
    check("wrap_instr", 32'(instr), 32'h155);
    instr_ready = 1'b1;
    tick();
    check("wrap_pc", 32'(pc), 32'd0);
    check("wrap_req", 32'(imem_req), 32'd1);
    repeat (6) tick();
    check("run_pc", 32'(pc), 32'd2);
`ifdef FETCH_COUNT_EN
    check("count3", 32'(instr_count), 32'd3);
`endif
    instr_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
